// File: rtl/sprite_pixel_fetch_pkg.sv
// Shared constants and types for the sprite pixel fetch pipeline.
// Holds sprite geometry, colour width, the default see-through key and orientation codes.
package sprite_pixel_fetch_pkg;

  localparam int SPRITE_DIM = 16;
  localparam int ADDR_W     = 8;
  localparam int RGB_W      = 24;
  localparam logic [RGB_W-1:0] TRANSPARENT_KEY_DEF = 24'h181b1d;

  typedef enum logic [1:0] {
    DIR_UL = 2'b00,
    DIR_UR = 2'b01,
    DIR_LL = 2'b10,
    DIR_LR = 2'b11
  } dir_e;

  function automatic logic [3:0] mirror4(input logic [3:0] coord, input logic flip);
    return flip ? (4'd15 - coord) : coord;
  endfunction

endpackage

// File: rtl/sprite_addr_map.sv
// Combinational raster-to-sprite mapping: hit test, local u/v and mirroring into a ROM address.
module sprite_addr_map
  import sprite_pixel_fetch_pkg::*;
#(
  parameter int COORD_W = 10
) (
  input  logic [COORD_W-1:0] pix_x,
  input  logic [COORD_W-1:0] pix_y,
  input  logic [COORD_W-1:0] org_x,
  input  logic [COORD_W-1:0] org_y,
  input  logic [1:0]         dir,
  output logic               hit,
  output logic [ADDR_W-1:0]  addr
);

  logic [COORD_W:0] dx_s;
  logic [COORD_W:0] dy_s;
  logic             flip_u_s;
  logic             flip_v_s;

  // Extra MSB keeps a raster position left of or above the origin from aliasing into 0..15
  always_comb begin
    dx_s = {1'b0, pix_x} - {1'b0, org_x};
    dy_s = {1'b0, pix_y} - {1'b0, org_y};
    hit  = (dx_s[COORD_W:4] == {(COORD_W-3){1'b0}}) &&
           (dy_s[COORD_W:4] == {(COORD_W-3){1'b0}});
  end

  // Orientation decode into per-axis flips
  always_comb begin
    flip_u_s = 1'b0;
    flip_v_s = 1'b0;
    case (dir_e'(dir))
      DIR_UL: begin flip_u_s = 1'b0; flip_v_s = 1'b0; end
      DIR_UR: begin flip_u_s = 1'b1; flip_v_s = 1'b0; end
      DIR_LL: begin flip_u_s = 1'b0; flip_v_s = 1'b1; end
      DIR_LR: begin flip_u_s = 1'b1; flip_v_s = 1'b1; end
      default: begin flip_u_s = 1'b0; flip_v_s = 1'b0; end
    endcase
  end

  // Row-major address {v', u'}
  always_comb begin
    addr = {mirror4(dy_s[3:0], flip_v_s), mirror4(dx_s[3:0], flip_u_s)};
  end

endmodule

// File: rtl/sprite_pixel_fetch.sv
// Two-stage sprite pixel pipeline: address generation, then ROM colour capture,
// with a per-frame saturating count of opaque sprite pixels.
module sprite_pixel_fetch
  import sprite_pixel_fetch_pkg::*;
#(
  parameter logic [RGB_W-1:0] TRANSPARENT_KEY = 24'h181b1d,
  parameter int               COORD_W         = 10
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_frame_start,
  input  logic               i_pix_valid,
  input  logic [COORD_W-1:0] i_pix_x,
  input  logic [COORD_W-1:0] i_pix_y,
  input  logic [COORD_W-1:0] i_org_x,
  input  logic [COORD_W-1:0] i_org_y,
  input  logic [1:0]         i_dir,
  output logic [ADDR_W-1:0]  o_rom_addr,
  input  logic [RGB_W-1:0]   i_rom_data,
  output logic               o_pix_valid,
  output logic               o_pix_hit,
  output logic               o_pix_opaque,
  output logic [RGB_W-1:0]   o_pix_rgb,
  output logic [8:0]         o_hit_count
);

  logic [COORD_W-1:0] org_x_r;
  logic [COORD_W-1:0] org_y_r;
  logic [1:0]         dir_r;
  logic [COORD_W-1:0] org_x_s;
  logic [COORD_W-1:0] org_y_s;
  logic [1:0]         dir_s;
  logic               map_hit_s;
  logic [ADDR_W-1:0]  map_addr_s;
  logic               s1_valid_r;
  logic               s1_hit_r;

  // A pixel on the frame-start cycle already sees the new origin and orientation
  always_comb begin
    if (i_frame_start) begin
      org_x_s = i_org_x;
      org_y_s = i_org_y;
      dir_s   = i_dir;
    end else begin
      org_x_s = org_x_r;
      org_y_s = org_y_r;
      dir_s   = dir_r;
    end
  end

  sprite_addr_map #(.COORD_W(COORD_W)) u_addr_map (
    .pix_x (i_pix_x),
    .pix_y (i_pix_y),
    .org_x (org_x_s),
    .org_y (org_y_s),
    .dir   (dir_s),
    .hit   (map_hit_s),
    .addr  (map_addr_s)
  );

  // Shadow origin/orientation, frozen for the rest of the frame
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      org_x_r <= {COORD_W{1'b0}};
      org_y_r <= {COORD_W{1'b0}};
      dir_r   <= 2'b00;
    end else if (i_frame_start) begin
      org_x_r <= i_org_x;
      org_y_r <= i_org_y;
      dir_r   <= i_dir;
    end
  end

  // Stage 1 addresses the ROM; stage 2 captures its combinational colour
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      s1_valid_r   <= 1'b0;
      s1_hit_r     <= 1'b0;
      o_rom_addr   <= {ADDR_W{1'b0}};
      o_pix_valid  <= 1'b0;
      o_pix_hit    <= 1'b0;
      o_pix_opaque <= 1'b0;
      o_pix_rgb    <= {RGB_W{1'b0}};
    end else begin
      s1_valid_r <= i_pix_valid;
      s1_hit_r   <= i_pix_valid & map_hit_s;
      if (i_pix_valid) begin
        o_rom_addr <= map_addr_s;
      end
      o_pix_valid  <= s1_valid_r;
      o_pix_hit    <= s1_hit_r;
      o_pix_opaque <= s1_hit_r && (i_rom_data != TRANSPARENT_KEY);
      o_pix_rgb    <= s1_hit_r ? i_rom_data : {RGB_W{1'b0}};
    end
  end

  // Opaque-pixel count; a frame start clears it even if an increment is due
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_hit_count <= 9'd0;
    end else if (i_frame_start) begin
      o_hit_count <= 9'd0;
    end else if (o_pix_valid && o_pix_opaque && (o_hit_count != 9'd256)) begin
      o_hit_count <= o_hit_count + 9'd1;
    end
  end

endmodule

// File: tb/tb_sprite_pixel_fetch.sv
// Directed bench for sprite_pixel_fetch with a small combinational ROM model.
module tb_sprite_pixel_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        frame_start;
  logic        pix_valid;
  logic [9:0]  pix_x, pix_y, org_x, org_y;
  logic [1:0]  dir;
  logic [7:0]  rom_addr;
  logic [23:0] rom_data;
  logic        out_valid, out_hit, out_opaque;
  logic [23:0] out_rgb;
  logic [8:0]  hit_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // ROM: entry 0 and every multiple of 5 hold the key (52 entries), entry 3 is 074b2b
  function automatic logic [23:0] rom_f(input logic [7:0] a);
    if (a == 8'd3)              return 24'h074b2b;
    else if ((a % 8'd5) == 8'd0) return 24'h181b1d;
    else                        return {a, ~a, 8'h33};
  endfunction

  always_comb rom_data = rom_f(rom_addr);

  sprite_pixel_fetch dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_frame_start (frame_start),
    .i_pix_valid   (pix_valid),
    .i_pix_x       (pix_x),
    .i_pix_y       (pix_y),
    .i_org_x       (org_x),
    .i_org_y       (org_y),
    .i_dir         (dir),
    .o_rom_addr    (rom_addr),
    .i_rom_data    (rom_data),
    .o_pix_valid   (out_valid),
    .o_pix_hit     (out_hit),
    .o_pix_opaque  (out_opaque),
    .o_pix_rgb     (out_rgb),
    .o_hit_count   (hit_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frame(input logic [9:0] ox, input logic [9:0] oy, input logic [1:0] d);
    org_x = ox; org_y = oy; dir = d; frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  // Drive one pixel and wait until its stage-2 result is on the outputs
  task automatic send_pix(input logic [9:0] x, input logic [9:0] y);
    pix_x = x; pix_y = y; pix_valid = 1'b1;
    tick();
    pix_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    total++;
    if ({out_valid, out_hit, out_opaque, out_rgb, rom_addr, hit_count} !== 59'd0) begin
      bad++;
      $display("FAIL reset_outputs got v=%b h=%b o=%b rgb=%h addr=%0d cnt=%0d want all 0",
               out_valid, out_hit, out_opaque, out_rgb, rom_addr, hit_count);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    frame(10'd100, 10'd50, 2'd0);
    send_pix(10'd103, 10'd50);
    total++;
    if ({out_valid, out_hit, out_opaque, rom_addr, out_rgb} !== {3'b111, 8'd3, 24'h074b2b}) begin
      bad++;
      $display("FAIL basic_opaque got v%b h%b o%b addr=%0d rgb=%h want 111 addr=3 rgb=074b2b",
               out_valid, out_hit, out_opaque, rom_addr, out_rgb);
    end
    send_pix(10'd100, 10'd50);
    total++;
    if ({out_valid, out_hit, out_opaque, rom_addr, out_rgb} !== {3'b110, 8'd0, 24'h181b1d}) begin
      bad++;
      $display("FAIL basic_key got v%b h%b o%b addr=%0d rgb=%h want 110 addr=0 rgb=181b1d",
               out_valid, out_hit, out_opaque, rom_addr, out_rgb);
    end
    send_pix(10'd116, 10'd50);
    total++;
    if ({out_valid, out_hit, out_opaque, out_rgb} !== {3'b100, 24'h0}) begin
      bad++;
      $display("FAIL basic_miss got v%b h%b o%b rgb=%h want 100 rgb=0",
               out_valid, out_hit, out_opaque, out_rgb);
    end
  endtask

  task automatic test_dir();
    frame(10'd100, 10'd50, 2'd1);
    send_pix(10'd100, 10'd50);
    total++;
    if (rom_addr !== 8'd15) begin bad++; $display("FAIL dir1_addr got %0d want 15", rom_addr); end
    frame(10'd100, 10'd50, 2'd3);
    send_pix(10'd100, 10'd50);
    total++;
    if (rom_addr !== 8'd255) begin bad++; $display("FAIL dir3_addr got %0d want 255", rom_addr); end
    frame(10'd100, 10'd50, 2'd2);
    send_pix(10'd100, 10'd65);
    total++;
    if ({out_hit, rom_addr} !== {1'b1, 8'd0}) begin
      bad++; $display("FAIL dir2_addr got hit=%b addr=%0d want hit=1 addr=0", out_hit, rom_addr);
    end
  endtask

  task automatic test_nowrap();
    frame(10'd1020, 10'd50, 2'd0);
    send_pix(10'd3, 10'd50);
    total++;
    if (out_hit !== 1'b0) begin bad++; $display("FAIL nowrap_low got hit=%b want 0", out_hit); end
    send_pix(10'd1023, 10'd50);
    total++;
    if ({out_hit, rom_addr} !== {1'b1, 8'd3}) begin
      bad++; $display("FAIL nowrap_edge got hit=%b addr=%0d want hit=1 addr=3", out_hit, rom_addr);
    end
  endtask

  task automatic test_shadow();
    frame(10'd100, 10'd50, 2'd0);
    org_x = 10'd200;
    send_pix(10'd103, 10'd50);
    total++;
    if ({out_hit, rom_addr} !== {1'b1, 8'd3}) begin
      bad++; $display("FAIL shadow_hold got hit=%b addr=%0d want hit=1 addr=3", out_hit, rom_addr);
    end
    frame_start = 1'b1; pix_x = 10'd203; pix_y = 10'd50; pix_valid = 1'b1;
    tick();
    frame_start = 1'b0; pix_valid = 1'b0;
    tick();
    total++;
    if ({out_valid, out_hit, rom_addr} !== {2'b11, 8'd3}) begin
      bad++; $display("FAIL shadow_bypass got v=%b hit=%b addr=%0d want 1 1 3", out_valid, out_hit, rom_addr);
    end
    send_pix(10'd103, 10'd50);
    total++;
    if (out_hit !== 1'b0) begin bad++; $display("FAIL shadow_new got hit=%b want 0", out_hit); end
  endtask

  task automatic test_back_to_back();
    int vcount = 0;
    frame(10'd100, 10'd50, 2'd0);
    for (int v = 0; v < 16; v++) begin
      for (int u = 0; u < 16; u++) begin
        pix_x = 10'(100 + u); pix_y = 10'(50 + v); pix_valid = 1'b1;
        tick();
        if (out_valid) vcount++;
      end
    end
    pix_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (out_valid) vcount++;
    end
    total++;
    if (vcount != 256) begin bad++; $display("FAIL sweep_valids got %0d want 256", vcount); end
    total++;
    if (hit_count !== 9'd204) begin bad++; $display("FAIL sweep_count got %0d want 204", hit_count); end
  endtask

  task automatic test_saturate();
    frame(10'd100, 10'd50, 2'd0);
    pix_x = 10'd103; pix_y = 10'd50; pix_valid = 1'b1;
    for (int k = 0; k < 300; k++) tick();
    total++;
    if (hit_count !== 9'd256) begin bad++; $display("FAIL sat_count got %0d want 256", hit_count); end
    // Frame start while opaque outputs keep arriving: clear must win, then counting resumes
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    total++;
    if (hit_count !== 9'd0) begin bad++; $display("FAIL clear_wins got %0d want 0", hit_count); end
    tick();
    total++;
    if (hit_count !== 9'd1) begin bad++; $display("FAIL count_resume got %0d want 1", hit_count); end
    pix_valid = 1'b0;
    tick(); tick();
  endtask

  task automatic test_reset_midframe();
    frame(10'd100, 10'd50, 2'd0);
    pix_x = 10'd103; pix_y = 10'd50; pix_valid = 1'b1;
    for (int k = 0; k < 10; k++) tick();
    rst_n = 1'b0;
    tick();
    total++;
    if ({out_valid, out_hit, out_opaque, out_rgb, rom_addr, hit_count} !== 59'd0) begin
      bad++;
      $display("FAIL midreset_outputs got v=%b h=%b o=%b rgb=%h addr=%0d cnt=%0d want all 0",
               out_valid, out_hit, out_opaque, out_rgb, rom_addr, hit_count);
    end
    pix_valid = 1'b0;
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL midreset_flush cycle %0d got valid=%b want 0", k, out_valid); end
    end
  endtask

  initial begin
    rst_n = 1'b0; frame_start = 1'b0; pix_valid = 1'b0;
    pix_x = '0; pix_y = '0; org_x = '0; org_y = '0; dir = 2'd0;
    test_reset();
    test_basic();
    test_dir();
    test_nowrap();
    test_shadow();
    test_back_to_back();
    test_saturate();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sprite_pixel_fetch.md
SPRITE_PIXEL_FETCH -- requirements
Module: sprite_pixel_fetch

Interface
REQ-001 SHALL have parameter TRANSPARENT_KEY, default 24'h181b1d, the sprite colour that is treated as see-through.
REQ-002 SHALL have parameter COORD_W, default 10, the width of the pixel coordinates.
REQ-003 SHALL have port i_clk, input, 1, the single clock; all logic is clocked on its rising edge.
REQ-004 SHALL have port i_rst_n, input, 1, reset; synchronous and active-low.
REQ-005 SHALL have port i_frame_start, input, 1, a one-cycle strobe at the start of each frame.
REQ-006 SHALL have port i_pix_valid, input, 1, qualifies i_pix_x and i_pix_y.
REQ-007 SHALL have ports i_pix_x and i_pix_y, input, COORD_W each, the current raster coordinates.
REQ-008 SHALL have ports i_org_x and i_org_y, input, COORD_W each, the sprite top-left corner.
REQ-009 SHALL have port i_dir, input, 2, the orientation: bit0 mirrors horizontally, bit1 mirrors vertically.
REQ-010 SHALL have port o_rom_addr, output, 8, the address to the 16x16 sprite ROM, row-major {v,u}.
REQ-011 SHALL have port i_rom_data, input, 24, the combinational ROM data for o_rom_addr.
REQ-012 SHALL have ports o_pix_valid, o_pix_hit and o_pix_opaque, output, 1 each.
REQ-013 SHALL have port o_pix_rgb, output, 24, the sprite colour.
REQ-014 SHALL have port o_hit_count, output, 9, the count of opaque pixels in the current frame.

Function
REQ-015 SHALL latch i_org_x, i_org_y and i_dir into shadow registers only on a cycle with i_frame_start=1; mid-frame changes SHALL be ignored.
REQ-016 SHALL evaluate a pixel presented on the same cycle as i_frame_start against the newly sampled origin and dir (bypass), not the old shadow values.
REQ-017 SHALL compute hit = (x-org_x) in 0..15 AND (y-org_y) in 0..15, using COORD_W+1-bit unsigned subtraction with no wrap-around: an origin near the maximum coordinate never hits low coordinates.
REQ-018 SHALL form u = x-org_x and v = y-org_y, each 4-bit.
REQ-019 SHALL form u' = dir[0] ? 15-u : u and v' = dir[1] ? 15-v : v, with o_rom_addr = v'*16 + u'.
REQ-020 Stage 1 SHALL register o_rom_addr, valid and hit; o_rom_addr SHALL hold its value when i_pix_valid=0.
REQ-021 Stage 2 SHALL register o_pix_valid, o_pix_hit and o_pix_rgb = hit ? i_rom_data : 0.
REQ-022 SHALL set o_pix_opaque = hit AND i_rom_data != TRANSPARENT_KEY.
REQ-023 Latency SHALL be 2 cycles from i_pix_valid to o_pix_valid; throughput SHALL be one pixel per cycle with no stalls.
REQ-024 o_hit_count SHALL increment on each stage-2 output with valid and opaque set, saturating at 256.
REQ-025 o_hit_count SHALL clear to 0 on i_frame_start; if an increment coincides with i_frame_start, the clear SHALL win.

Reset
REQ-026 With i_rst_n=0 at a clock edge, all outputs SHALL go to 0, the shadow origin and dir SHALL go to 0, and both pipeline stages SHALL be invalidated.
REQ-027 A reset mid-frame SHALL drop all in-flight pixels, so that no o_pix_valid is asserted in the 2 cycles after release unless new input is supplied.

Structure
REQ-028 The package SHALL hold SPRITE_DIM=16, the sprite address width (8), the RGB width (24), the transparent key, and a typedef enum for i_dir (DIR_UL, DIR_UR, DIR_LL, DIR_LR).
REQ-029 The coordinate-to-address stage SHALL be one sub-module, sprite_addr_map (combinational hit/u/v/mirror); the pipeline and counter SHALL live in the top level.

Verification
REQ-030 Origin (100,50), dir 0, pixel (103,50) -> 2 cycles later: addr 3, rgb 074b2b, hit=1, opaque=1.
REQ-031 Same origin, pixel (100,50) -> addr 0, rgb 181b1d, hit=1, opaque=0; pixel (116,50) -> hit=0, rgb 0.
REQ-032 dir 1, pixel (100,50) -> addr 15; dir 3, pixel (100,50) -> addr 255; dir 2, pixel (100,65) -> addr 0.
REQ-033 Origin x=1020, pixel (3,y0) -> hit=0 (no wrap); pixel (1023,y0) -> hit=1, addr 3.
REQ-034 Change i_org_x mid-frame -> hits unchanged until the next i_frame_start; a pixel on the frame_start cycle uses the new origin.
REQ-035 Full 16x16 sweep at dir 0 -> o_hit_count = number of non-key entries; i_rst_n low mid-sweep -> all outputs 0 next cycle and count 0.
